// File: rtl/sweep_regfile.sv
// sweep_regfile: 32 x WIDTH register file that clears itself by sweeping after reset; SWEEP_REGFILE_BYPASS_EN adds same-cycle write-to-read bypass
module sweep_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             RegWrite,
    output logic             Ready
);
    localparam logic CLEAR = 1'b0;
    localparam logic RUN   = 1'b1;

    logic             state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [32];
    logic             we;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;

    // sweep advances one register per edge and parks at 31 when entering RUN
    always_comb begin
        state_d = (state_q == CLEAR && cnt_q == 5'd31) ? RUN : state_q;
        cnt_d   = (state_q == CLEAR && cnt_q != 5'd31) ? cnt_q + 5'd1 : cnt_q;
    end

    // state and sweep counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // single write port shared by the clearing sweep and user writes; reset drops both
    always_comb begin
        we    = !Reset && (state_q == CLEAR || (RegWrite && WriteRegister != 5'd0));
        waddr = (state_q == CLEAR) ? cnt_q : WriteRegister;
        wdata = (state_q == CLEAR) ? '0 : WriteData;
    end

    // register array; entry 0 is never written and never read
    always_ff @(posedge Clk) begin
        if (we)
            regs_q[waddr] <= wdata;
    end

    assign Ready = (state_q == RUN);

`ifdef SWEEP_REGFILE_BYPASS_EN
    logic byp;
    // forward in-flight write data to a matching read port
    always_comb begin
        byp       = Ready && RegWrite && WriteRegister != 5'd0;
        ReadData1 = (!Ready || ReadRegister1 == 5'd0) ? '0 :
                    (byp && ReadRegister1 == WriteRegister) ? WriteData : regs_q[ReadRegister1];
        ReadData2 = (!Ready || ReadRegister2 == 5'd0) ? '0 :
                    (byp && ReadRegister2 == WriteRegister) ? WriteData : regs_q[ReadRegister2];
    end
`else
    // plain combinational reads, zeroed while not ready and for register 0
    always_comb begin
        ReadData1 = (!Ready || ReadRegister1 == 5'd0) ? '0 : regs_q[ReadRegister1];
        ReadData2 = (!Ready || ReadRegister2 == 5'd0) ? '0 : regs_q[ReadRegister2];
    end
`endif
endmodule
